box_motion_ctrl: RTL
====================

Name: box_motion_ctrl

Overview:
- Controller for the on-screen box overlay in the VGA path.
- Debounces the four direction buttons and sequences position updates so the box moves at most once per frame, during vertical blank, which avoids tearing.
- Clamps the box to the visible area.
- Drives the overlay hit signal (draw_box) that the pixel colour mux ORs with the digit overlays.

Parameters:
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- BOX_SIZE, 32, box side in pixels
- STEP, 4, pixels moved per update
- DEBOUNCE_CYCLES, 500000, consecutive stable clk_50 cycles needed to accept a button change (10 ms at 50 MHz)
- INIT_X, 304, reset x of top-left corner
- INIT_Y, 224, reset y of top-left corner

Ports:
- clk_50  in  1  system clock (same clock as the vga counter)
- reset  in  1  asynchronous, active-high reset
- btn_up, btn_down, btn_left, btn_right  in  1 each  raw asynchronous buttons
- mode  in  1  0 = one step per press, 1 = continuous step every frame while held
- row  in  10  current scan row from the vga counter
- x, y  in  10  current pixel coordinate
- box_x, box_y  out  10  registered top-left position of the box
- moving  out  1  high during any frame in which a position update was applied; cleared at the next frame tick
- draw_box  out  1  combinational; x in [box_x, box_x+BOX_SIZE) and y in [box_y, box_y+BOX_SIZE)

Behaviour:
- Reset (async): box_x=INIT_X, box_y=INIT_Y, moving=0, FSM=S_IDLE, debounced levels=0, sync flops=0, frame-edge flop=0. Reset mid-operation abandons any pending move.
- Debounce, per button:
  - 2-FF synchroniser.
  - A counter resets whenever the synced level differs from the debounced level.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the levels still different, the debounced level takes the synced level.
  - Latency from a clean edge: 2 + DEBOUNCE_CYCLES cycles.
- Frame tick: 1-cycle pulse on the rising edge of (row >= SCREEN_H), i.e. the first cycle of vertical blank.
- Direction vector: dy from up/down, dx from left/right. If both buttons of an axis are pressed, that axis is 0. Diagonal movement is allowed.
- FSM (any_dir = dx!=0 or dy!=0):
  - S_IDLE: any_dir -> S_WAIT_FRAME.
  - S_WAIT_FRAME: !any_dir -> S_IDLE; frame tick -> S_APPLY.
  - S_APPLY (exactly 1 cycle): update box_x/box_y from the dx/dy sampled this cycle; set moving=1. Then mode=1 -> S_WAIT_FRAME, mode=0 -> S_WAIT_RELEASE.
  - S_WAIT_RELEASE: !any_dir -> S_IDLE.
- moving: cleared on every frame tick that does not coincide with S_APPLY.
- Arithmetic: computed in 11 bits, then truncated to 10.
  - +STEP: min(pos+STEP, LIMIT), where LIMIT = SCREEN_W-BOX_SIZE for x and SCREEN_H-BOX_SIZE for y.
  - -STEP: pos<STEP ? 0 : pos-STEP.
  - Already at the limit: the position is unchanged but moving is still set.
- mode is sampled only in S_APPLY. Changing it mid-hold takes effect at the next apply.
- Position changes only in S_APPLY, which always falls in vertical blank, so draw_box never changes shape mid-frame.

Optional Feature:
- Macro BOX_WRAP_EN.
  - Defined: the axis wraps instead of clamping. +STEP past LIMIT gives 0; -STEP from a position below STEP gives LIMIT.
  - Undefined: clamp as above.

Decomposition:
- Package vga_pkg holds:
  - SCREEN_W_C and SCREEN_H_C constants.
  - box_state_t enum {S_IDLE, S_WAIT_FRAME, S_APPLY, S_WAIT_RELEASE}.
  - dir_t enum {DIR_NEG, DIR_NONE, DIR_POS}.
- One sub-module, btn_debounce #(DEBOUNCE_CYCLES), with a synchroniser and counter, instantiated four times.

Test Plan (DEBOUNCE_CYCLES=4, short row sweep):
- Reset released -> box_x=304, box_y=224, moving=0; draw_box=1 at (x,y)=(304,224) and 0 at (336,224).
- mode=0, btn_right held across 3 frame ticks -> box_x=308 after the first tick only; no further change until release and a new press.
- mode=1, btn_up held 5 frames from box_y=8 -> box_y sequence 4, 0, 0, 0, 0; moving=1 in each of those frames.
- btn_left and btn_right both held plus btn_down, mode=1 -> box_x unchanged, box_y +4 per frame.
- Button glitch of 3 cycles -> no debounced change, FSM stays in S_IDLE; with BOX_WRAP_EN, box_x=608 and a right press -> box_x=0.
- Reset asserted while in S_WAIT_FRAME with a press pending -> outputs return to reset values immediately; no move on the next tick.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared screen constants, box FSM/direction types and the per-axis step helper.
// Build option BOX_WRAP_EN makes the step helper wrap at the screen edges instead of clamping.
package vga_pkg;
  localparam int SCREEN_W_C = 640;
  localparam int SCREEN_H_C = 480;
  typedef enum logic [1:0] {S_IDLE, S_WAIT_FRAME, S_APPLY, S_WAIT_RELEASE} box_state_t;
  typedef enum logic [1:0] {DIR_NEG, DIR_NONE, DIR_POS} dir_t;
  function automatic logic [9:0] step_pos(input logic [9:0] pos, input dir_t d,
                                          input logic [10:0] stp, input logic [10:0] lim);
    logic [10:0] p;
    logic [10:0] s;
    logic [10:0] r;
    p = {1'b0, pos};
    s = p + stp;
`ifdef BOX_WRAP_EN
    r = d == DIR_POS ? (s > lim ? 11'd0 : s) : d == DIR_NEG ? (p < stp ? lim : p - stp) : p;
`else
    r = d == DIR_POS ? (s > lim ? lim : s) : d == DIR_NEG ? (p < stp ? 11'd0 : p - stp) : p;
`endif
    return r[9:0];
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser plus stability counter; the level follows the
// synced input only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic s1_q, s2_q, lvl_q;
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      lvl_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q <= btn_i;
      s2_q <= s1_q;
      if (s2_q == lvl_q) cnt_q <= '0;
      else if (cnt_q == LAST) begin
        lvl_q <= s2_q;
        cnt_q <= '0;
      end else cnt_q <= cnt_q + 1'b1;
    end
  assign level_o = lvl_q;
endmodule

// File: rtl/box_motion_ctrl.sv
// box_motion_ctrl: debounced box mover that applies at most one step per frame, in vertical blank.
// Edge behaviour (clamp vs. wrap) is selected by BOX_WRAP_EN via vga_pkg::step_pos.
module box_motion_ctrl
  import vga_pkg::*;
#(
  parameter int SCREEN_W        = SCREEN_W_C,
  parameter int SCREEN_H        = SCREEN_H_C,
  parameter int BOX_SIZE        = 32,
  parameter int STEP            = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int INIT_X          = 304,
  parameter int INIT_Y          = 224
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       mode,
  input  logic [9:0] row,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [9:0] box_x,
  output logic [9:0] box_y,
  output logic       moving,
  output logic       draw_box
);
  localparam logic [10:0] LIM_X = 11'(SCREEN_W - BOX_SIZE);
  localparam logic [10:0] LIM_Y = 11'(SCREEN_H - BOX_SIZE);
  localparam logic [10:0] STP   = 11'(STEP);
  localparam logic [10:0] BOX   = 11'(BOX_SIZE);
  logic [3:0] raw, lvl;
  logic [9:0] box_x_q, box_y_q, box_x_d, box_y_d;
  logic moving_q, vb_q, vblank, tick, any_dir;
  dir_t dx, dy;
  box_state_t state_q;
  assign raw = {btn_up, btn_down, btn_left, btn_right};
  for (genvar i = 0; i < 4; i++) begin : g_deb
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk(clk_50), .rst(reset), .btn_i(raw[i]), .level_o(lvl[i])
    );
  end
  // Opposing buttons on one axis cancel; screen y grows downward.
  assign dx = (lvl[0] & ~lvl[1]) ? DIR_POS : (lvl[1] & ~lvl[0]) ? DIR_NEG : DIR_NONE;
  assign dy = (lvl[2] & ~lvl[3]) ? DIR_POS : (lvl[3] & ~lvl[2]) ? DIR_NEG : DIR_NONE;
  assign any_dir = (dx != DIR_NONE) || (dy != DIR_NONE);
  assign vblank  = row >= 10'(SCREEN_H);
  assign tick    = vblank & ~vb_q;
  assign box_x_d = step_pos(box_x_q, dx, STP, LIM_X);
  assign box_y_d = step_pos(box_y_q, dy, STP, LIM_Y);
  always_ff @(posedge clk_50 or posedge reset)
    if (reset) begin
      state_q  <= S_IDLE;
      box_x_q  <= 10'(INIT_X);
      box_y_q  <= 10'(INIT_Y);
      moving_q <= 1'b0;
      vb_q     <= 1'b0;
    end else begin
      vb_q <= vblank;
      if (tick) moving_q <= 1'b0;
      case (state_q)
        S_IDLE:         if (any_dir) state_q <= S_WAIT_FRAME;
        S_WAIT_FRAME:   state_q <= !any_dir ? S_IDLE : tick ? S_APPLY : S_WAIT_FRAME;
        S_APPLY: begin
          box_x_q  <= box_x_d;
          box_y_q  <= box_y_d;
          moving_q <= 1'b1;
          state_q  <= mode ? S_WAIT_FRAME : S_WAIT_RELEASE;
        end
        S_WAIT_RELEASE: if (!any_dir) state_q <= S_IDLE;
        default:        state_q <= S_IDLE;
      endcase
    end
  assign box_x    = box_x_q;
  assign box_y    = box_y_q;
  assign moving   = moving_q;
  assign draw_box = ({1'b0, x} >= {1'b0, box_x_q}) && ({1'b0, x} < {1'b0, box_x_q} + BOX) &&
                    ({1'b0, y} >= {1'b0, box_y_q}) && ({1'b0, y} < {1'b0, box_y_q} + BOX);
endmodule
